// File: rtl/rr_req_arbiter.sv
// Round-robin request arbiter: registered one-hot grant with valid/ready handoff; optional RR_ARB_HOLD_EN.
// Latency: one cycle from req to grant_valid; minimum two cycles per grant (IDLE bubble).
// Backpressure: grant held stable until grant_ready; optional HOLD keeps grant while req[winner] stays high.
module rr_req_arbiter #(
    parameter int WIDTH = 3,
    parameter int LINES = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LINES-1:0] req,
    input  logic             grant_ready,
    output logic [LINES-1:0] grant,
    output logic             grant_valid,
    output logic             busy
);

`ifdef RR_ARB_HOLD_EN
    typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;
`else
    typedef enum logic {IDLE, OFFER} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ptr, ptr_nxt;
    logic [WIDTH-1:0] gidx, gidx_nxt;
    logic [LINES-1:0] grant_nxt;
    logic             valid_nxt;
    logic             win_found;
    logic [WIDTH-1:0] win_idx;
    logic [WIDTH-1:0] scan_idx;

    // Scan from ptr upward; the index wraps naturally because LINES is 2**WIDTH.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < LINES; i++) begin
            scan_idx = ptr + WIDTH'(i);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        grant_nxt = grant;
        valid_nxt = grant_valid;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    valid_nxt          = 1'b1;
                    gidx_nxt           = win_idx;
                    state_nxt          = OFFER;
                end
            end
            OFFER: begin
                if (grant_ready) begin
                    ptr_nxt   = gidx + WIDTH'(1);
                    valid_nxt = 1'b0;
`ifdef RR_ARB_HOLD_EN
                    state_nxt = HOLD;
`else
                    grant_nxt = '0;
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef RR_ARB_HOLD_EN
            HOLD: begin
                // Ownership lasts as long as the winning line keeps requesting.
                if (!req[gidx]) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                grant_nxt = '0;
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gidx        <= gidx_nxt;
            grant       <= grant_nxt;
            grant_valid <= valid_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
